// File: rtl/fab_apb_arbiter.sv
// fab_apb_arbiter
// Two-requester round-robin arbiter driving a single APB master port toward
// the MSS fabric slave. Each transfer walks IDLE -> SETUP -> ACCESS -> DONE;
// the granted requester sees a one-cycle DONEn pulse with RDATAn/ERRn, which
// then hold until that requester's next completion.
// Optional feature: define FAB_APB_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT cycles without FABPREADY (completes with ERRn=1, RDATAn=0).
// All outputs are registered; reset is synchronous, active-low.

module fab_apb_arbiter #(
   parameter int unsigned TIMEOUT = 32'd255
) (
   input  logic        FAB_CLK,
   input  logic        M2FRESETn,
   input  logic        REQ0,
   input  logic        REQ1,
   input  logic        WR0,
   input  logic        WR1,
   input  logic [31:0] ADDR0,
   input  logic [31:0] ADDR1,
   input  logic [31:0] WDATA0,
   input  logic [31:0] WDATA1,
   output logic        DONE0,
   output logic        DONE1,
   output logic [31:0] RDATA0,
   output logic [31:0] RDATA1,
   output logic        ERR0,
   output logic        ERR1,
   output logic [31:0] FABPADDR,
   output logic [31:0] FABPWDATA,
   output logic        FABPWRITE,
   output logic        FABPSEL,
   output logic        FABPENABLE,
   input  logic [31:0] FABPRDATA,
   input  logic        FABPREADY,
   input  logic        FABPSLVERR
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t      state_r,      state_nxt_s;
   logic        grant_r,      grant_nxt_s;
   logic        last_grant_r, last_grant_nxt_s;
   logic [31:0] paddr_r,      paddr_nxt_s;
   logic [31:0] pwdata_r,     pwdata_nxt_s;
   logic        pwrite_r,     pwrite_nxt_s;
   logic        psel_r,       psel_nxt_s;
   logic        penable_r,    penable_nxt_s;
   logic        done0_r,      done0_nxt_s;
   logic        done1_r,      done1_nxt_s;
   logic [31:0] rdata0_r,     rdata0_nxt_s;
   logic [31:0] rdata1_r,     rdata1_nxt_s;
   logic        err0_r,       err0_nxt_s;
   logic        err1_r,       err1_nxt_s;

   logic        pick_s;
   logic        finish_s;
   logic [31:0] rsp_rdata_s;
   logic        rsp_err_s;
   logic        timeout_hit_s;

   // Elaboration guard: an out-of-range TIMEOUT (outside 1..65535) opens this
   // empty, visibly named scope in the hierarchy so a bad override is easy to spot.
   if ((TIMEOUT < 32'd1) || (TIMEOUT > 32'd65535)) begin : g_timeout_out_of_range
   end

`ifdef FAB_APB_TIMEOUT_EN
   localparam logic [16:0] TIMEOUT_C = 17'(TIMEOUT);

   logic [15:0] to_cnt_r;

   assign timeout_hit_s = (state_r == ST_ACCESS) && !FABPREADY &&
                          (({1'b0, to_cnt_r} + 17'd1) == TIMEOUT_C);

   // Counts ACCESS cycles without FABPREADY; cleared whenever ACCESS is left.
   always_ff @(posedge FAB_CLK) begin
      if (!M2FRESETn) begin
         to_cnt_r <= 16'd0;
      end else if ((state_r == ST_ACCESS) && !FABPREADY && !timeout_hit_s) begin
         to_cnt_r <= to_cnt_r + 16'd1;
      end else begin
         to_cnt_r <= 16'd0;
      end
   end
`else
   assign timeout_hit_s = 1'b0;
`endif

   // Round-robin pick: on a tie the requester not served last wins.
   always_comb begin
      pick_s = 1'b0;
      if (REQ0 && REQ1) begin
         pick_s = ~last_grant_r;
      end else if (REQ1) begin
         pick_s = 1'b1;
      end else begin
         pick_s = 1'b0;
      end
   end

   // Completion response of the ACCESS phase (slave answer or timeout abort).
   always_comb begin
      finish_s    = 1'b0;
      rsp_rdata_s = 32'd0;
      rsp_err_s   = 1'b0;
      if (FABPREADY) begin
         finish_s    = 1'b1;
         rsp_rdata_s = pwrite_r ? 32'd0 : FABPRDATA;
         rsp_err_s   = FABPSLVERR;
      end else if (timeout_hit_s) begin
         finish_s    = 1'b1;
         rsp_rdata_s = 32'd0;
         rsp_err_s   = 1'b1;
      end else begin
         finish_s    = 1'b0;
      end
   end

   // Next-state and next-output logic of the transfer FSM.
   always_comb begin
      state_nxt_s      = state_r;
      grant_nxt_s      = grant_r;
      last_grant_nxt_s = last_grant_r;
      paddr_nxt_s      = paddr_r;
      pwdata_nxt_s     = pwdata_r;
      pwrite_nxt_s     = pwrite_r;
      psel_nxt_s       = psel_r;
      penable_nxt_s    = penable_r;
      done0_nxt_s      = 1'b0;
      done1_nxt_s      = 1'b0;
      rdata0_nxt_s     = rdata0_r;
      rdata1_nxt_s     = rdata1_r;
      err0_nxt_s       = err0_r;
      err1_nxt_s       = err1_r;

      case (state_r)
         ST_IDLE: begin
            if (REQ0 || REQ1) begin
               grant_nxt_s      = pick_s;
               last_grant_nxt_s = pick_s;
               paddr_nxt_s      = pick_s ? ADDR1  : ADDR0;
               pwdata_nxt_s     = pick_s ? WDATA1 : WDATA0;
               pwrite_nxt_s     = pick_s ? WR1    : WR0;
               psel_nxt_s       = 1'b1;
               penable_nxt_s    = 1'b0;
               state_nxt_s      = ST_SETUP;
            end else begin
               psel_nxt_s       = 1'b0;
               penable_nxt_s    = 1'b0;
            end
         end

         ST_SETUP: begin
            psel_nxt_s    = 1'b1;
            penable_nxt_s = 1'b1;
            state_nxt_s   = ST_ACCESS;
         end

         ST_ACCESS: begin
            if (finish_s) begin
               psel_nxt_s    = 1'b0;
               penable_nxt_s = 1'b0;
               state_nxt_s   = ST_DONE;
               if (grant_r) begin
                  done1_nxt_s  = 1'b1;
                  rdata1_nxt_s = rsp_rdata_s;
                  err1_nxt_s   = rsp_err_s;
               end else begin
                  done0_nxt_s  = 1'b1;
                  rdata0_nxt_s = rsp_rdata_s;
                  err0_nxt_s   = rsp_err_s;
               end
            end else begin
               psel_nxt_s    = 1'b1;
               penable_nxt_s = 1'b1;
            end
         end

         ST_DONE: begin
            // Requests seen here are ignored; a held REQn restarts from IDLE.
            psel_nxt_s    = 1'b0;
            penable_nxt_s = 1'b0;
            state_nxt_s   = ST_IDLE;
         end

         default: begin
            psel_nxt_s    = 1'b0;
            penable_nxt_s = 1'b0;
            state_nxt_s   = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any transfer in flight.
   always_ff @(posedge FAB_CLK) begin
      if (!M2FRESETn) begin
         state_r      <= ST_IDLE;
         grant_r      <= 1'b0;
         last_grant_r <= 1'b1;
         paddr_r      <= 32'd0;
         pwdata_r     <= 32'd0;
         pwrite_r     <= 1'b0;
         psel_r       <= 1'b0;
         penable_r    <= 1'b0;
         done0_r      <= 1'b0;
         done1_r      <= 1'b0;
         rdata0_r     <= 32'd0;
         rdata1_r     <= 32'd0;
         err0_r       <= 1'b0;
         err1_r       <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         grant_r      <= grant_nxt_s;
         last_grant_r <= last_grant_nxt_s;
         paddr_r      <= paddr_nxt_s;
         pwdata_r     <= pwdata_nxt_s;
         pwrite_r     <= pwrite_nxt_s;
         psel_r       <= psel_nxt_s;
         penable_r    <= penable_nxt_s;
         done0_r      <= done0_nxt_s;
         done1_r      <= done1_nxt_s;
         rdata0_r     <= rdata0_nxt_s;
         rdata1_r     <= rdata1_nxt_s;
         err0_r       <= err0_nxt_s;
         err1_r       <= err1_nxt_s;
      end
   end

   assign FABPADDR   = paddr_r;
   assign FABPWDATA  = pwdata_r;
   assign FABPWRITE  = pwrite_r;
   assign FABPSEL    = psel_r;
   assign FABPENABLE = penable_r;
   assign DONE0      = done0_r;
   assign DONE1      = done1_r;
   assign RDATA0     = rdata0_r;
   assign RDATA1     = rdata1_r;
   assign ERR0       = err0_r;
   assign ERR1       = err1_r;

endmodule

// File: doc/fab_apb_arbiter.md
FAB_APB_ARBITER -- requirements
Module: fab_apb_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 255, number of ACCESS cycles without FABPREADY before the transfer is aborted (range 1..65535; used only with FAB_APB_TIMEOUT_EN).
REQ-002 SHALL have port: FAB_CLK  in  1  the single clock, which is the MSS CCC fabric clock.
REQ-003 SHALL have port: M2FRESETn  in  1  reset; synchronous, active-low.
REQ-004 SHALL have ports REQ0/REQ1  in  1 each; WR0/WR1  in  1 each; ADDR0/ADDR1  in  32 each; WDATA0/WDATA1  in  32 each. Together these carry the per-requester command: REQ is the request, WR is 1 for write, and ADDR/WDATA are the address and write data.
REQ-005 SHALL have ports DONE0/DONE1  out  1 each; RDATA0/RDATA1  out  32 each; ERR0/ERR1  out  1 each. These are the per-requester completion pulse, read data and error flag.
REQ-006 SHALL have ports FABPADDR  out  32; FABPWDATA  out  32; FABPWRITE  out  1; FABPSEL  out  1; FABPENABLE  out  1. These form the APB master toward the MSS fabric slave port.
REQ-007 SHALL have ports FABPRDATA  in  32; FABPREADY  in  1; FABPSLVERR  in  1. These are the APB responses from the MSS.

Function
REQ-008 SHALL implement the FSM states IDLE, SETUP, ACCESS and DONE.
REQ-009 In IDLE with any REQn=1, the block SHALL grant one requester, register its WR/ADDR/WDATA onto the FABP* outputs and go to SETUP at the next edge.
REQ-010 Arbitration SHALL be round-robin: if both requesters request, the one not granted last wins; if only one requests, it is granted immediately.
REQ-011 SETUP SHALL drive FABPSEL=1, FABPENABLE=0, last exactly one cycle, then go to ACCESS.
REQ-012 ACCESS SHALL drive FABPSEL=1, FABPENABLE=1; FABPADDR/FABPWDATA/FABPWRITE SHALL stay stable from SETUP until ACCESS exits.
REQ-013 In ACCESS with FABPREADY=1, the block SHALL register FABPRDATA (on reads; 0 on writes) into RDATAn and FABPSLVERR into ERRn of the granted requester, then go to DONE.
REQ-014 DONE SHALL last one cycle with FABPSEL=FABPENABLE=0, DONEn=1 only for the granted requester, RDATAn/ERRn valid, then go to IDLE.
REQ-015 Latency: REQ sampled at edge k gives SETUP in cycle k+1, ACCESS in k+2 and, with zero wait states, DONE in k+3. Each FABPREADY=0 cycle adds one cycle.
REQ-016 RDATAn/ERRn SHALL hold their value until that requester's next DONE.
REQ-017 A requester SHALL hold REQn and its command stable until its DONEn. REQn sampled during DONE SHALL be ignored; REQn=1 in a later IDLE is a new transfer.
REQ-018 A REQn rising while the other requester's transfer is in progress SHALL wait; it SHALL be granted in the next IDLE ahead of the requester just served.
REQ-019 FABPREADY/FABPSLVERR outside ACCESS SHALL be ignored.

Reset
REQ-020 While M2FRESETn=0 at an edge: state=IDLE, all outputs=0, last-grant pointer=1 (so requester 0 wins the first tie), timeout counter=0.
REQ-021 Reset during SETUP/ACCESS/DONE SHALL abort the transfer: FABPSEL/FABPENABLE low at the next edge and no DONEn issued.

Configuration
REQ-022 With macro FAB_APB_TIMEOUT_EN defined, a 16-bit counter SHALL count ACCESS cycles with FABPREADY=0. When it reaches TIMEOUT, the block SHALL go to DONE with ERRn=1 and RDATAn=0, and clear the counter on exit from ACCESS.
REQ-023 Without FAB_APB_TIMEOUT_EN, ACCESS SHALL wait indefinitely for FABPREADY, with no counter logic present; TIMEOUT is unused.

Verification
REQ-024 Single read, no wait: REQ0, WR0=0, ADDR0=0x40000010, FABPRDATA=0xDEADBEEF, FABPREADY=1 -> FABPSEL high cycles k+1..k+2, FABPENABLE high k+2, DONE0 at k+3 with RDATA0=0xDEADBEEF, ERR0=0.
REQ-025 Write with 3 wait states: REQ1, WR1=1, ADDR1=0x40000020, WDATA1=0x12345678, FABPREADY low for 3 ACCESS cycles -> FABPADDR/FABPWDATA stable throughout, DONE1 at k+6, RDATA1=0.
REQ-026 Simultaneous REQ0/REQ1 from reset, both held -> grant order 0,1,0,1; each DONE separated by a 4-cycle transfer; no overlapping FABPSEL.
REQ-027 Slave error: FABPSLVERR=1 with FABPREADY=1 on a read from REQ0 -> DONE0 with ERR0=1; ERR0 holds until the next DONE0.
REQ-028 Reset mid-ACCESS: M2FRESETn=0 during ACCESS -> next cycle all outputs 0, no DONE. With FAB_APB_TIMEOUT_EN and TIMEOUT=4, FABPREADY held 0 -> DONE0 with ERR0=1, RDATA0=0 after 4 ACCESS cycles.
